classifier_loader: RTL and testbench

- Byte-stream model loader and prediction gate for the SVM classifier.
- Parses BLE bytes (count, support-vector records, bias), writes records into the classifier's support-vector memory, and publishes the bias and vector count.
- Sits between the BLE UART/byte receiver and the classifier core.
- Gates predict_enable so the classifier never predicts on a partially loaded model.

---
 rtl/classifier_pkg.sv | 20 ++
 rtl/classifier_loader_byte_assembler.sv | 53 +++++
 rtl/classifier_loader.sv | 192 +++++++++++++++++++
 tb/tb_classifier_loader.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/classifier_pkg.sv
// Shared defaults, loader state encoding and field typedefs for the SVM model loader.
package classifier_pkg;

    localparam int DEF_MAX_SV         = 32;
    localparam int DEF_SV_BYTES       = 6;
    localparam int DEF_BIAS_BYTES     = 4;
    localparam int DEF_TIMEOUT_CYCLES = 1000000;

    typedef enum logic [2:0] {
        IDLE,
        RX_SV,
        RX_BIAS,
        CHECK,
        COMMIT
    } loader_state_t;

    typedef logic [DEF_SV_BYTES*8-1:0]          sv_record_t;
    typedef logic signed [DEF_BIAS_BYTES*8-1:0] bias_t;

endpackage

// File: rtl/classifier_loader_byte_assembler.sv
// Generic little-endian shift-in register: the first byte ends up in bits [7:0] once NBYTES bytes have arrived.
module byte_assembler #(
    parameter int NBYTES = 4
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic                  clear_in,
    input  logic                  valid_in,
    input  logic [7:0]            byte_in,
    output logic [NBYTES*8-1:0]   word_out,
    output logic                  done_out
);

    localparam int CNT_W = $clog2(NBYTES + 1);

    logic [NBYTES*8-1:0] word_q, word_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                done_q, done_d;

    // done pulses the cycle after the final byte, when word_q already holds the full word
    always_comb begin
        word_d = word_q;
        cnt_d  = cnt_q;
        done_d = 1'b0;
        if (clear_in) begin
            cnt_d = '0;
        end else if (valid_in) begin
            word_d = {byte_in, word_q[NBYTES*8-1:8]};
            if (cnt_q == CNT_W'(NBYTES - 1)) begin
                cnt_d  = '0;
                done_d = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            word_q <= '0;
            cnt_q  <= '0;
            done_q <= 1'b0;
        end else begin
            word_q <= word_d;
            cnt_q  <= cnt_d;
            done_q <= done_d;
        end
    end

    assign word_out = word_q;
    assign done_out = done_q;

endmodule

// File: rtl/classifier_loader.sv
// Byte-stream SVM model loader: parses count, support-vector records and bias, then gates prediction.
// Defining CLASSIFIER_LOADER_CHECKSUM_EN adds a trailing XOR checksum byte verified before commit.
module classifier_loader
    import classifier_pkg::*;
#(
    parameter int MAX_SV         = DEF_MAX_SV,
    parameter int SV_BYTES       = DEF_SV_BYTES,
    parameter int BIAS_BYTES     = DEF_BIAS_BYTES,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic                          clk_in,
    input  logic                          rst_in,
    input  logic [7:0]                    ble_data_in,
    input  logic                          ble_valid_in,
    input  logic                          predict_enable_in,
    output logic                          predict_enable_out,
    output logic                          sv_wr_en_out,
    output logic [$clog2(MAX_SV)-1:0]     sv_wr_addr_out,
    output logic [SV_BYTES*8-1:0]         sv_wr_data_out,
    output logic [$clog2(MAX_SV+1)-1:0]   num_sv_out,
    output logic [BIAS_BYTES*8-1:0]       bias_out,
    output logic                          model_ready_out,
    output logic                          error_out
);

    localparam int ADDR_W = $clog2(MAX_SV);
    localparam int NSV_W  = $clog2(MAX_SV + 1);
    localparam int GAP_W  = $clog2(TIMEOUT_CYCLES + 1);

    loader_state_t           state_q, state_d;
    logic [NSV_W-1:0]        nCnt_q, nCnt_d, numSv_q, numSv_d;
    logic [ADDR_W-1:0]       recIdx_q, recIdx_d;
    logic [GAP_W-1:0]        gapCnt_q, gapCnt_d;
    logic [BIAS_BYTES*8-1:0] bias_q, bias_d;
    logic                    ready_q, ready_d, error_q, error_d;
    logic                    timeout, badCount;
    logic                    svClear, svValid, svDone;
    logic                    biasClear, biasValid, biasDone;
    logic [SV_BYTES*8-1:0]   svWord;
    logic [BIAS_BYTES*8-1:0] biasWord;
`ifdef CLASSIFIER_LOADER_CHECKSUM_EN
    logic [7:0]              xor_q, xor_d;
`endif

    byte_assembler #(.NBYTES(SV_BYTES)) u_svAsm (
        .clk_in   (clk_in),
        .rst_in   (rst_in),
        .clear_in (svClear),
        .valid_in (svValid),
        .byte_in  (ble_data_in),
        .word_out (svWord),
        .done_out (svDone)
    );

    byte_assembler #(.NBYTES(BIAS_BYTES)) u_biasAsm (
        .clk_in   (clk_in),
        .rst_in   (rst_in),
        .clear_in (biasClear),
        .valid_in (biasValid),
        .byte_in  (ble_data_in),
        .word_out (biasWord),
        .done_out (biasDone)
    );

    assign timeout  = (state_q != IDLE) && (gapCnt_q == GAP_W'(TIMEOUT_CYCLES));
    assign badCount = (ble_data_in == 8'd0) || (32'(ble_data_in) > MAX_SV);

    // Timeout takes priority over any byte in the same cycle; committed outputs change only in COMMIT
    always_comb begin
        state_d   = state_q;
        nCnt_d    = nCnt_q;
        numSv_d   = numSv_q;
        recIdx_d  = recIdx_q;
        gapCnt_d  = '0;
        bias_d    = bias_q;
        ready_d   = ready_q;
        error_d   = 1'b0;
        svClear   = 1'b0;
        svValid   = 1'b0;
        biasClear = 1'b0;
        biasValid = 1'b0;
`ifdef CLASSIFIER_LOADER_CHECKSUM_EN
        xor_d     = xor_q;
`endif
        if (state_q != IDLE) begin
            gapCnt_d = ble_valid_in ? '0 : gapCnt_q + 1'b1;
        end
        if (timeout) begin
            gapCnt_d = '0;
            error_d  = 1'b1;
            state_d  = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (ble_valid_in) begin
                        if (badCount) begin
                            error_d = 1'b1;
                        end else begin
                            nCnt_d    = NSV_W'(ble_data_in);
                            ready_d   = 1'b0;
                            recIdx_d  = '0;
                            svClear   = 1'b1;
                            biasClear = 1'b1;
                            state_d   = RX_SV;
`ifdef CLASSIFIER_LOADER_CHECKSUM_EN
                            xor_d     = ble_data_in;
`endif
                        end
                    end
                end
                RX_SV: begin
                    svValid = ble_valid_in;
`ifdef CLASSIFIER_LOADER_CHECKSUM_EN
                    if (ble_valid_in) xor_d = xor_q ^ ble_data_in;
`endif
                    if (svDone) begin
                        recIdx_d = recIdx_q + 1'b1;
                        if ((NSV_W'(recIdx_q) + NSV_W'(1)) == nCnt_q) begin
                            state_d = RX_BIAS;
                        end
                    end
                end
                RX_BIAS: begin
                    biasValid = ble_valid_in;
`ifdef CLASSIFIER_LOADER_CHECKSUM_EN
                    if (ble_valid_in) xor_d = xor_q ^ ble_data_in;
                    if (biasDone) state_d = CHECK;
`else
                    if (biasDone) state_d = COMMIT;
`endif
                end
`ifdef CLASSIFIER_LOADER_CHECKSUM_EN
                CHECK: begin
                    if (ble_valid_in) begin
                        if (ble_data_in == xor_q) begin
                            state_d = COMMIT;
                        end else begin
                            error_d = 1'b1;
                            state_d = IDLE;
                        end
                    end
                end
`endif
                COMMIT: begin
                    bias_d  = biasWord;
                    numSv_d = nCnt_q;
                    ready_d = 1'b1;
                    state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q  <= IDLE;
            nCnt_q   <= '0;
            numSv_q  <= '0;
            recIdx_q <= '0;
            gapCnt_q <= '0;
            bias_q   <= '0;
            ready_q  <= 1'b0;
            error_q  <= 1'b0;
`ifdef CLASSIFIER_LOADER_CHECKSUM_EN
            xor_q    <= '0;
`endif
        end else begin
            state_q  <= state_d;
            nCnt_q   <= nCnt_d;
            numSv_q  <= numSv_d;
            recIdx_q <= recIdx_d;
            gapCnt_q <= gapCnt_d;
            bias_q   <= bias_d;
            ready_q  <= ready_d;
            error_q  <= error_d;
`ifdef CLASSIFIER_LOADER_CHECKSUM_EN
            xor_q    <= xor_d;
`endif
        end
    end

    assign sv_wr_en_out       = svDone && (state_q == RX_SV);
    assign sv_wr_addr_out     = recIdx_q;
    assign sv_wr_data_out     = svWord;
    assign num_sv_out         = numSv_q;
    assign bias_out           = bias_q;
    assign model_ready_out    = ready_q;
    assign error_out          = error_q;
    assign predict_enable_out = predict_enable_in & ready_q;

endmodule

// File: tb/tb_classifier_loader.sv
// Self-checking bench for classifier_loader: directed and random frames compared against a byte-level frame model.
module tb_classifier_loader;

    localparam int MAX_SV     = 32;
    localparam int SV_BYTES   = 6;
    localparam int BIAS_BYTES = 4;
    localparam int TIMEOUT    = 50;
`ifdef CLASSIFIER_LOADER_CHECKSUM_EN
    localparam int READY_LAT  = 1;
`else
    localparam int READY_LAT  = 2;
`endif

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic [7:0]  ble_data_in;
    logic        ble_valid_in;
    logic        predict_enable_in;
    logic        predict_enable_out;
    logic        sv_wr_en_out;
    logic [4:0]  sv_wr_addr_out;
    logic [47:0] sv_wr_data_out;
    logic [5:0]  num_sv_out;
    logic [31:0] bias_out;
    logic        model_ready_out;
    logic        error_out;

    classifier_loader #(
        .MAX_SV         (MAX_SV),
        .SV_BYTES       (SV_BYTES),
        .BIAS_BYTES     (BIAS_BYTES),
        .TIMEOUT_CYCLES (TIMEOUT)
    ) dut (
        .clk_in             (clk_in),
        .rst_in             (rst_in),
        .ble_data_in        (ble_data_in),
        .ble_valid_in       (ble_valid_in),
        .predict_enable_in  (predict_enable_in),
        .predict_enable_out (predict_enable_out),
        .sv_wr_en_out       (sv_wr_en_out),
        .sv_wr_addr_out     (sv_wr_addr_out),
        .sv_wr_data_out     (sv_wr_data_out),
        .num_sv_out         (num_sv_out),
        .bias_out           (bias_out),
        .model_ready_out    (model_ready_out),
        .error_out          (error_out)
    );

    always #5 clk_in = ~clk_in;

    int          checks = 0;
    int          errors = 0;
    int          errCnt = 0;
    int          errBase;
    int          waitCyc;
    int          nSv;
    logic [31:0] prevBias;
    logic [5:0]  prevNum;
    logic [4:0]  wrAddr[$];
    logic [47:0] wrData[$];
    logic [7:0]  payload[$];
    logic [47:0] expRec[$];
    logic [31:0] expBias;
    logic [7:0]  dirBytes [34];
`ifdef CLASSIFIER_LOADER_CHECKSUM_EN
    logic [7:0]  ckFlip = 8'h00;
    logic [7:0]  ckBytes [10];
`endif

    // Scoreboard capture of memory writes and error pulses, sampled away from the active edge
    always @(negedge clk_in) begin
        if (sv_wr_en_out) begin
            wrAddr.push_back(sv_wr_addr_out);
            wrData.push_back(sv_wr_data_out);
        end
        if (error_out) errCnt++;
    end

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [7:0] b);
        @(posedge clk_in); #1;
        ble_data_in  = b;
        ble_valid_in = 1'b1;
        @(posedge clk_in); #1;
        ble_valid_in = 1'b0;
    endtask

    task automatic buildPayload(input int n);
        payload.delete();
        repeat (n * SV_BYTES + BIAS_BYTES) payload.push_back(8'($urandom));
    endtask

    // Reference model: records and bias are little-endian slices of the payload byte list
    task automatic modelFrame(input int n);
        logic [47:0] rec;
        expRec.delete();
        for (int r = 0; r < n; r++) begin
            rec = '0;
            for (int j = 0; j < SV_BYTES; j++) rec[8*j +: 8] = payload[r*SV_BYTES + j];
            expRec.push_back(rec);
        end
        expBias = '0;
        for (int j = 0; j < BIAS_BYTES; j++) expBias[8*j +: 8] = payload[n*SV_BYTES + j];
    endtask

    task automatic loadFrame(input int n, input int gap);
`ifdef CLASSIFIER_LOADER_CHECKSUM_EN
        logic [7:0] ck;
        ck = 8'(n);
`endif
        wrAddr.delete();
        wrData.delete();
        applyStimulus(8'(n));
        foreach (payload[i]) begin
            repeat (gap) @(posedge clk_in);
            applyStimulus(payload[i]);
`ifdef CLASSIFIER_LOADER_CHECKSUM_EN
            ck ^= payload[i];
`endif
        end
`ifdef CLASSIFIER_LOADER_CHECKSUM_EN
        repeat (gap) @(posedge clk_in);
        applyStimulus(ck ^ ckFlip);
`endif
    endtask

    task automatic checkCommit(input int n, input string tag);
        checkOutput($sformatf("%s_ready_before", tag), model_ready_out, 0);
        for (int c = 1; c <= READY_LAT; c++) begin
            @(posedge clk_in); #1;
            checkOutput($sformatf("%s_ready_c%0d", tag, c), model_ready_out, (c == READY_LAT));
        end
        checkOutput($sformatf("%s_nwrites", tag), wrAddr.size(), n);
        for (int i = 0; i < n && i < wrAddr.size(); i++) begin
            checkOutput($sformatf("%s_addr%0d", tag, i), wrAddr[i], i);
            checkOutput($sformatf("%s_data%0d", tag, i), wrData[i], expRec[i]);
        end
        checkOutput($sformatf("%s_bias", tag), bias_out, expBias);
        checkOutput($sformatf("%s_num_sv", tag), num_sv_out, n);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        rst_in            = 1'b0;
        ble_data_in       = 8'h00;
        ble_valid_in      = 1'b0;
        predict_enable_in = 1'b1;
        dirBytes = '{8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'hEF, 8'hBE,
                     8'h01, 8'h23, 8'h45, 8'h67, 8'h76, 8'h54,
                     8'h11, 8'h05, 8'h45, 8'h08, 8'h00, 8'h19,
                     8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'hFF,
                     8'h10, 8'h20, 8'h30, 8'h40, 8'h50, 8'h60,
                     8'h07, 8'h65, 8'h43, 8'h21};
        repeat (3) @(posedge clk_in); #1;

        checkOutput("rst_ready", model_ready_out, 0);
        checkOutput("rst_num_sv", num_sv_out, 0);
        checkOutput("rst_bias", bias_out, 0);
        checkOutput("rst_error", error_out, 0);
        checkOutput("rst_wr_en", sv_wr_en_out, 0);
        checkOutput("rst_predict", predict_enable_out, 0);
        rst_in = 1'b1;

        // Directed frame: five records, bytes 11 cycles apart
        payload.delete();
        foreach (dirBytes[i]) payload.push_back(dirBytes[i]);
        modelFrame(5);
        loadFrame(5, 9);
        checkCommit(5, "dir");
        checkOutput("dir_rec0_const", wrData[0], 48'hBEEFDEADBEEF);
        checkOutput("dir_rec1_const", wrData[1], 48'h547667452301);
        checkOutput("dir_rec4_const", wrData[4], 48'h605040302010);
        checkOutput("dir_bias_const", bias_out, 32'h21436507);

        // Prediction gating, then a new upload that stalls after one record
        predict_enable_in = 1'b0;
        #1;
        checkOutput("pred_off", predict_enable_out, 0);
        predict_enable_in = 1'b1;
        #1;
        checkOutput("pred_on", predict_enable_out, 1);
        buildPayload(2);
        modelFrame(2);
        wrAddr.delete();
        wrData.delete();
        applyStimulus(8'd2);
        checkOutput("newcnt_ready_drop", model_ready_out, 0);
        checkOutput("newcnt_pred_drop", predict_enable_out, 0);
        for (int i = 0; i < SV_BYTES; i++) applyStimulus(payload[i]);
        errBase = errCnt;
        waitCyc = 0;
        while (!error_out && waitCyc < 2 * TIMEOUT) begin
            @(posedge clk_in); #1;
            waitCyc++;
        end
        checkOutput("to_error_seen", error_out, 1);
        checkOutput("to_window", (waitCyc >= TIMEOUT) && (waitCyc <= TIMEOUT + 2), 1);
        checkOutput("to_writes", wrAddr.size(), 1);
        checkOutput("to_wr_data", wrData[0], expRec[0]);
        @(posedge clk_in); #1;
        checkOutput("to_error_pulse", errCnt - errBase, 1);
        checkOutput("to_ready", model_ready_out, 0);

        // Random frames including both count boundaries
        for (int t = 0; t < 4; t++) begin
            nSv = (t == 0) ? 1 : (t == 1) ? MAX_SV : int'($urandom_range(2, MAX_SV - 1));
            buildPayload(nSv);
            modelFrame(nSv);
            loadFrame(nSv, int'($urandom_range(0, 3)));
            checkCommit(nSv, $sformatf("rnd%0d", t));
        end
        prevBias = expBias;
        prevNum  = 6'(nSv);

        // Illegal counts are rejected without disturbing the committed model
        wrAddr.delete();
        errBase = errCnt;
        applyStimulus(8'd0);
        repeat (3) @(posedge clk_in);
        applyStimulus(8'(MAX_SV + 1));
        repeat (3) @(posedge clk_in); #1;
        checkOutput("badcnt_errors", errCnt - errBase, 2);
        checkOutput("badcnt_ready", model_ready_out, 1);
        checkOutput("badcnt_bias", bias_out, prevBias);
        checkOutput("badcnt_num_sv", num_sv_out, prevNum);
        checkOutput("badcnt_writes", wrAddr.size(), 0);

        // Reset three bytes into record 2
        buildPayload(3);
        applyStimulus(8'd3);
        for (int i = 0; i < 2 * SV_BYTES + 3; i++) applyStimulus(payload[i]);
        #2;
        rst_in = 1'b0;
        #1;
        checkOutput("midrst_ready", model_ready_out, 0);
        checkOutput("midrst_bias", bias_out, 0);
        checkOutput("midrst_num_sv", num_sv_out, 0);
        checkOutput("midrst_wr_en", sv_wr_en_out, 0);
        checkOutput("midrst_wr_data", sv_wr_data_out, 0);
        checkOutput("midrst_predict", predict_enable_out, 0);
        repeat (2) @(posedge clk_in); #1;
        rst_in = 1'b1;
        nSv = int'($urandom_range(1, MAX_SV));
        buildPayload(nSv);
        modelFrame(nSv);
        loadFrame(nSv, 1);
        checkCommit(nSv, "postrst");

`ifdef CLASSIFIER_LOADER_CHECKSUM_EN
        ckBytes = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE, 8'hFF, 8'h01, 8'h02, 8'h03, 8'h04};
        payload.delete();
        foreach (ckBytes[i]) payload.push_back(ckBytes[i]);
        modelFrame(1);
        ckFlip = 8'h00;
        loadFrame(1, 2);
        checkCommit(1, "ck_ok");
        errBase = errCnt;
        ckFlip  = 8'h5A;
        loadFrame(1, 2);
        repeat (3) @(posedge clk_in); #1;
        checkOutput("ck_bad_error", errCnt - errBase, 1);
        checkOutput("ck_bad_ready", model_ready_out, 0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
